approx_err_monitor: RTL and testbench

//  Downstream checker for the 16-bit approximate Brent-Kung adder under evaluation.

---
 rtl/approx_err_monitor_if.sv | 14 +
 rtl/approx_err_monitor.sv | 149 ++++++++++++++
 tb/tb_approx_err_monitor.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_err_monitor_if.sv
// Vector stream from the adder under test into the error monitor.
// The master presents a, b and the adder's sum s_dut with in_valid; the monitor answers with in_ready.
interface approx_err_monitor_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s_dut;

    modport master (output in_valid, a, b, s_dut, input in_ready);
    modport slave  (input in_valid, a, b, s_dut, output in_ready);
endinterface

// File: rtl/approx_err_monitor.sv
// Error monitor for an approximate adder: compares each DUT sum with the exact sum and
// accumulates error count, saturating sum of error distance, max distance and first failing index.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting vectors until n_samples have been taken
// DRAIN | no more accepts, letting the two pipeline stages empty
// DONE  | stats final, done held until the next start
module approx_err_monitor #(
    parameter int W     = 16,
    parameter int CNT_W = 20,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    approx_err_monitor_if.slave  vec,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     n_samples_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     err_count_o,
    output logic [ACC_W-1:0]     sum_ed_o,
    output logic [W:0]           max_ed_o,
    output logic                 first_err_vld_o,
    output logic [CNT_W-1:0]     first_err_idx_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   accepted_q;

    logic               s1_vld_q;
    logic [W-1:0]       s1_a_q;
    logic [W-1:0]       s1_b_q;
    logic [W:0]         s1_s_q;
    logic [CNT_W-1:0]   s1_idx_q;

    logic               s2_vld_q;
    logic               s2_err_q;
    logic [W:0]         s2_ed_q;
    logic [CNT_W-1:0]   s2_idx_q;

    logic [CNT_W-1:0]   err_count_q;
    logic [ACC_W-1:0]   sum_ed_q;
    logic [W:0]         max_ed_q;
    logic               first_err_vld_q;
    logic [CNT_W-1:0]   first_err_idx_q;

    logic               in_ready;
    logic               accept;
    logic [W:0]         exact;
    logic [W:0]         ed;
    logic [ACC_W:0]     sum_ed_d;

    assign in_ready     = (state_q == S_RUN) && (accepted_q < n_q);
    assign vec.in_ready = in_ready;
    assign accept       = vec.in_valid & in_ready;

    // Exact sum keeps the carry; the magnitude of a (W+1)-bit difference always fits in W+1 bits.
    assign exact = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign ed    = (exact >= s1_s_q) ? (exact - s1_s_q) : (s1_s_q - exact);

    assign sum_ed_d = {1'b0, sum_ed_q} + {{(ACC_W - W){1'b0}}, s2_ed_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            n_q             <= '0;
            accepted_q      <= '0;
            s1_vld_q        <= 1'b0;
            s1_a_q          <= '0;
            s1_b_q          <= '0;
            s1_s_q          <= '0;
            s1_idx_q        <= '0;
            s2_vld_q        <= 1'b0;
            s2_err_q        <= 1'b0;
            s2_ed_q         <= '0;
            s2_idx_q        <= '0;
            err_count_q     <= '0;
            sum_ed_q        <= '0;
            max_ed_q        <= '0;
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_a_q     <= vec.a;
                s1_b_q     <= vec.b;
                s1_s_q     <= vec.s_dut;
                s1_idx_q   <= accepted_q;
                accepted_q <= accepted_q + 1'b1;
            end

            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_ed_q  <= ed;
                s2_err_q <= (ed != '0);
                s2_idx_q <= s1_idx_q;
            end

            if (s2_vld_q) begin
                err_count_q <= err_count_q + {{(CNT_W-1){1'b0}}, s2_err_q};
                // Once saturated the accumulator stays all-ones for the rest of the run.
                sum_ed_q    <= sum_ed_d[ACC_W] ? {ACC_W{1'b1}} : sum_ed_d[ACC_W-1:0];
                if (s2_ed_q > max_ed_q)
                    max_ed_q <= s2_ed_q;
                if (s2_err_q && !first_err_vld_q) begin
                    first_err_vld_q <= 1'b1;
                    first_err_idx_q <= s2_idx_q;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        n_q             <= n_samples_i;
                        accepted_q      <= '0;
                        err_count_q     <= '0;
                        sum_ed_q        <= '0;
                        max_ed_q        <= '0;
                        first_err_vld_q <= 1'b0;
                        first_err_idx_q <= '0;
                        state_q         <= (n_samples_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accepted_q == n_q)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!s1_vld_q && !s2_vld_q)
                        state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o          = (state_q == S_DONE);
    assign err_count_o     = err_count_q;
    assign sum_ed_o        = sum_ed_q;
    assign max_ed_o        = max_ed_q;
    assign first_err_vld_o = first_err_vld_q;
    assign first_err_idx_o = first_err_idx_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: single-vector table, directed multi-cycle sequences and
// random runs compared against an arithmetic model of the error metrics.
module tb_approx_err_monitor;
    localparam int W     = 16;
    localparam int CNT_W = 20;
    localparam int ACC_W = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_err_monitor_if #(.W(W)) bus ();

    logic             start_i;
    logic [CNT_W-1:0] n_samples_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] err_count_o;
    logic [ACC_W-1:0] sum_ed_o;
    logic [W:0]       max_ed_o;
    logic             first_err_vld_o;
    logic [CNT_W-1:0] first_err_idx_o;

    approx_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vec             (bus),
        .start_i         (start_i),
        .n_samples_i     (n_samples_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_count_o     (err_count_o),
        .sum_ed_o        (sum_ed_o),
        .max_ed_o        (max_ed_o),
        .first_err_vld_o (first_err_vld_o),
        .first_err_idx_o (first_err_idx_o)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] s;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] s;
        logic [16:0] ed;
    } tv_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t q[$];
    tv_t  tbl[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Error metrics straight from their definitions over the list of accepted vectors.
    task automatic model(output longint ec, output longint sum, output longint mx,
                         output longint fidx, output longint fv);
        ec = 0; sum = 0; mx = 0; fidx = 0; fv = 0;
        for (int i = 0; i < q.size(); i++) begin
            longint exact, d;
            exact = longint'(q[i].a) + longint'(q[i].b);
            d = exact - longint'(q[i].s);
            if (d < 0) d = -d;
            if (d != 0) ec++;
            sum += d;
            if (d > mx) mx = d;
            if (d != 0 && fv == 0) begin
                fv = 1;
                fidx = i;
            end
        end
    endtask

    task automatic check_stats(input string tag);
        longint ec, sum, mx, fidx, fv;
        model(ec, sum, mx, fidx, fv);
        chk({tag, ".err_count"}, 64'(err_count_o), ec);
        chk({tag, ".sum_ed"}, 64'(sum_ed_o), sum);
        chk({tag, ".max_ed"}, 64'(max_ed_o), mx);
        chk({tag, ".first_vld"}, 64'(first_err_vld_o), fv);
        chk({tag, ".first_idx"}, 64'(first_err_idx_o), fidx);
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic do_start(input int n);
        n_samples_i = CNT_W'(n);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send(input vec_t v, input string tag);
        bit ok;
        ok = 0;
        bus.a = v.a;
        bus.b = v.b;
        bus.s_dut = v.s;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (bus.in_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) chk({tag, ".accept_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 300; t++) begin
            if (done_o) break;
            @(negedge clk);
        end
        chk({tag, ".done"}, 64'(done_o), 64'd1);
    endtask

    task automatic run_q(input string tag, input bit gaps);
        do_start(q.size());
        foreach (q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(q[i], tag);
        end
        wait_done(tag);
        check_stats(tag);
        repeat (3) @(negedge clk);
        chk({tag, ".done_hold"}, 64'(done_o), 64'd1);
        check_stats({tag, ".stable"});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.s_dut = '0;
        start_i = 1'b0;
        n_samples_i = '0;

        tbl[0] = '{16'h0000, 16'h0000, 17'h00000, 17'h00000};
        tbl[1] = '{16'hFFFF, 16'h0001, 17'h10000, 17'h00000};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, 17'h00000};
        tbl[3] = '{16'h00FF, 16'h0001, 17'h000FF, 17'h00001};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 17'h00000, 17'h1FFFE};
        tbl[5] = '{16'h0000, 16'h0000, 17'h1FFFE, 17'h1FFFE};
        tbl[6] = '{16'h1234, 16'h4321, 17'h05555, 17'h00000};
        tbl[7] = '{16'h1234, 16'h4321, 17'h05554, 17'h00001};
        tbl[8] = '{16'h8000, 16'h8000, 17'h00000, 17'h10000};
        tbl[9] = '{16'h0001, 16'h0000, 17'h1FFFF, 17'h1FFFE};

        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy_o), 64'd0);
        chk("rst.done", 64'(done_o), 64'd0);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst.err_count", 64'(err_count_o), 64'd0);
        chk("rst.sum_ed", 64'(sum_ed_o), 64'd0);
        chk("rst.max_ed", 64'(max_ed_o), 64'd0);
        chk("rst.first_vld", 64'(first_err_vld_o), 64'd0);
        chk("rst.first_idx", 64'(first_err_idx_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            do_start(1);
            send('{tbl[i].a, tbl[i].b, tbl[i].s}, tag);
            wait_done(tag);
            chk({tag, ".err_count"}, 64'(err_count_o), 64'(tbl[i].ed != 0));
            chk({tag, ".sum_ed"}, 64'(sum_ed_o), 64'(tbl[i].ed));
            chk({tag, ".max_ed"}, 64'(max_ed_o), 64'(tbl[i].ed));
            chk({tag, ".first_vld"}, 64'(first_err_vld_o), 64'(tbl[i].ed != 0));
            chk({tag, ".first_idx"}, 64'(first_err_idx_o), 64'd0);
        end

        q.delete();
        q.push_back('{16'h0000, 16'h0000, 17'h00000});
        q.push_back('{16'hFFFF, 16'h0001, 17'h10000});
        q.push_back('{16'hFFFF, 16'hFFFF, 17'h1FFFE});
        q.push_back('{16'h1234, 16'h4321, 17'h05555});
        run_q("t1", 1'b0);
        chk("t1.err_count_const", 64'(err_count_o), 64'd0);

        q.delete();
        q.push_back('{16'h0001, 16'h0002, 17'h00003});
        q.push_back('{16'h00FF, 16'h0001, 17'h000FF});
        q.push_back('{16'h0010, 16'h0010, 17'h00020});
        run_q("t2", 1'b0);
        chk("t2.err_count_const", 64'(err_count_o), 64'd1);
        chk("t2.sum_ed_const", 64'(sum_ed_o), 64'd1);
        chk("t2.max_ed_const", 64'(max_ed_o), 64'd1);
        chk("t2.first_idx_const", 64'(first_err_idx_o), 64'd1);

        q.delete();
        q.push_back('{16'hFFFF, 16'hFFFF, 17'h00000});
        q.push_back('{16'h0000, 16'h0000, 17'h1FFFE});
        run_q("t3", 1'b1);
        chk("t3.max_ed_const", 64'(max_ed_o), 64'h1FFFE);
        chk("t3.sum_ed_const", 64'(sum_ed_o), 64'h3FFFC);
        chk("t3.err_count_const", 64'(err_count_o), 64'd2);
        chk("t3.first_idx_const", 64'(first_err_idx_o), 64'd0);

        // Zero-length run: straight to DONE with cleared stats.
        n_samples_i = '0;
        start_i = 1'b1;
        chk("t4.ready0", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        chk("t4.ready1", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("t4.done", 64'(done_o), 64'd1);
        chk("t4.ready2", 64'(bus.in_ready), 64'd0);
        chk("t4.busy", 64'(busy_o), 64'd0);
        chk("t4.err_count", 64'(err_count_o), 64'd0);
        chk("t4.sum_ed", 64'(sum_ed_o), 64'd0);
        chk("t4.max_ed", 64'(max_ed_o), 64'd0);
        chk("t4.first_vld", 64'(first_err_vld_o), 64'd0);

        // Gaps, an ignored mid-run start and an extra valid after the last accept.
        q.delete();
        q.push_back('{16'h0100, 16'h0200, 17'h00300});
        q.push_back('{16'h0100, 16'h0200, 17'h00308});
        q.push_back('{16'hABCD, 16'h1111, 17'h0BCDE});
        q.push_back('{16'h7FFF, 16'h7FFF, 17'h0FF00});
        q.push_back('{16'h0003, 16'h0004, 17'h00002});
        do_start(5);
        foreach (q[i]) begin
            if (i == 2) begin
                n_samples_i = CNT_W'(1);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
            repeat (i % 2 + 1) @(negedge clk);
            send(q[i], "t5");
        end
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.s_dut = 17'h00000;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("t5.extra_ready%0d", t), 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_done("t5");
        check_stats("t5");

        // Reset in the middle of a run discards everything.
        q.delete();
        q.push_back('{16'h0001, 16'h0001, 17'h00000});
        q.push_back('{16'h0002, 16'h0002, 17'h00000});
        q.push_back('{16'h0003, 16'h0003, 17'h00000});
        do_start(5);
        foreach (q[i]) send(q[i], "t6");
        repeat (3) @(negedge clk);
        chk("t6.pre_err_count", 64'(err_count_o), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_busy", 64'(busy_o), 64'd0);
        chk("t6.rst_ready", 64'(bus.in_ready), 64'd0);
        chk("t6.rst_err_count", 64'(err_count_o), 64'd0);
        chk("t6.rst_sum_ed", 64'(sum_ed_o), 64'd0);
        chk("t6.rst_max_ed", 64'(max_ed_o), 64'd0);
        chk("t6.rst_first_vld", 64'(first_err_vld_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6.post_busy", 64'(busy_o), 64'd0);
        chk("t6.post_done", 64'(done_o), 64'd0);
        q.delete();
        q.push_back('{16'h2222, 16'h3333, 17'h05555});
        run_q("t6b", 1'b0);
        chk("t6b.err_count_const", 64'(err_count_o), 64'd0);

        for (int r = 0; r < 15; r++) begin
            int n;
            n = $urandom_range(1, 12);
            q.delete();
            for (int i = 0; i < n; i++) begin
                vec_t v;
                logic [16:0] ex;
                v.a = 16'($urandom);
                v.b = 16'($urandom);
                ex = {1'b0, v.a} + {1'b0, v.b};
                case ($urandom_range(0, 3))
                    0, 1:    v.s = ex;
                    2:       v.s = ex ^ (17'd1 << $urandom_range(0, 16));
                    default: v.s = 17'($urandom);
                endcase
                q.push_back(v);
            end
            run_q($sformatf("rnd%0d", r), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
